ser_bit_feeder: RTL
===================

// Module: ser_bit_feeder
// PURPOSE
//   Upstream feeder for the serial sequence-detector stage. Accepts parallel words over a
//   valid/ready handshake and emits them as a one-bit-per-clock serial stream (ser_out),
//   which drives the detector's din input. A one-entry holding register lets back-to-back
//   words leave with no idle gap.
// PARAMETERS
//   DATA_W   8   width of the parallel input word; DATA_W >= 2
// PORTS
//   clk        in   1       single clock, all flops on posedge
//   rst        in   1       asynchronous, active-high reset
//   in_data    in   DATA_W  parallel word
//   in_valid   in   1       in_data valid
//   in_ready   out  1       holding register empty; word accepted on edge with valid&&ready
//   ser_out    out  1       serial bit to detector din; 0 whenever ser_valid=0
//   ser_valid  out  1       ser_out carries a real data bit this cycle
//   busy       out  1       state==SHIFT or hold_vld
//   word_done  out  1       one-cycle pulse in the cycle after the last bit of a word was shown
// BEHAVIOUR
//   Interface: one clock; reset is asynchronous and active-high.
//   Reset: state=IDLE, sh=0, cnt=0, hold=0, hold_vld=0, ser_valid=0, ser_out=0,
//     word_done=0, in_ready=1, busy=0. A reset mid-word drops the partial word and any held word.
//   in_ready = !hold_vld (register-driven, no combinational path from in_valid).
//   Accept edge T: hold<=in_data, hold_vld<=1.
//   FSM IDLE: if hold_vld -> sh<=hold, hold_vld<=0, cnt<=0, ser_valid<=1, go SHIFT.
//   FSM SHIFT: ser_out = sh[DATA_W-1] (registered source, MSB first).
//     cnt<DATA_W-1: sh<=sh<<1 (zero fill), cnt<=cnt+1.
//     cnt==DATA_W-1 (last bit): word_done<=1. If hold_vld: reload sh<=hold, hold_vld<=0,
//     cnt<=0, stay SHIFT, ser_valid stays 1 (gap-free). Otherwise sh<=0, ser_valid<=0, go IDLE.
//   Latency: a word accepted at edge T shows its first bit after edge T+1 and its last bit
//     after edge T+DATA_W. Each bit is held for exactly one cycle.
//   Accept and reload never coincide: hold_vld=1 forces in_ready=0. After a reload, in_ready
//     rises and the next word can be accepted within the DATA_W-1 remaining bit cycles.
//   cnt width = $clog2(DATA_W). It never exceeds DATA_W-1; no wrap-around beyond that.
//   in_data/in_valid are ignored while in_ready=0. The source must hold them stable.
// CONFIGURATION
//   SER_LSB_FIRST_EN defined: shift right (sh>>1), ser_out = sh[0], LSB transmitted first.
//   Not defined (default): MSB first as above. Timing, handshake and pulses are identical.
// STRUCTURE
//   Package ser_pkg: localparam DATA_W_DEF=8; typedef enum {S_IDLE, S_SHIFT} ser_state_t;
//     function cnt_w(DATA_W) returning $clog2(DATA_W).
//   Sub-module ser_hold_reg: one-entry buffer (hold, hold_vld, in_ready; load/take strobes).
//   Top level holds the FSM, shift register, bit counter and output flops.
// TESTING
//   1 Assert rst mid-cycle, then release -> all outputs at reset values; in_ready=1 immediately.
//   2 Send 8'h92 at edge T -> ser_valid=1 after edges T+1..T+8, ser_out=1,0,0,1,0,0,1,0;
//     word_done pulses after T+9; the detector sees 10010 and fires.
//   3 Send 8'h92 then 8'h4B back-to-back -> 16 contiguous ser_valid cycles with bits
//     10010010_01001011; in_ready=0 while the held word waits.
//   4 Hold in_valid=1 with hold full -> no accept; the held word is unchanged; the next
//     accept happens only after the reload edge.
//   5 Assert rst after 3 bits of 8'hFF -> ser_valid=0 and ser_out=0 at once; no word_done;
//     a new 8'h01 then serialises cleanly.
//   6 Build with SER_LSB_FIRST_EN, send 8'h92 -> ser_out=0,1,0,0,1,0,0,1, same timing as test 2.

Source files
------------

// File: rtl/ser_pkg.sv
// rtl/ser_pkg.sv - shared types and sizing helpers for the serial bit feeder
package ser_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [0:0] {
        S_IDLE,
        S_SHIFT
    } ser_state_t;

    function automatic int cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

endpackage

// File: rtl/ser_hold_reg.sv
// rtl/ser_hold_reg.sv - one-entry holding buffer in front of the shift register
module ser_hold_reg
    import ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              load,
    input  logic              take,
    output logic [DATA_W-1:0] hold,
    output logic              hold_vld,
    output logic              in_ready
);

    // in_ready is kept as its own flop so the upstream sees a pure register output
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold     <= '0;
            hold_vld <= 1'b0;
            in_ready <= 1'b1;
        end else if (load) begin
            hold     <= in_data;
            hold_vld <= 1'b1;
            in_ready <= 1'b0;
        end else if (take) begin
            hold_vld <= 1'b0;
            in_ready <= 1'b1;
        end
    end

endmodule

// File: rtl/ser_bit_feeder.sv
// rtl/ser_bit_feeder.sv - parallel-to-serial feeder for the sequence detector
// SER_LSB_FIRST_EN selects LSB-first transmission; default is MSB first.
module ser_bit_feeder
    import ser_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ser_out,
    output logic              ser_valid,
    output logic              busy,
    output logic              word_done
);

    localparam int            CW   = cnt_w(DATA_W);
    localparam logic [CW-1:0] LAST = CW'(DATA_W - 1);

    ser_state_t        state;
    logic [DATA_W-1:0] sh;
    logic [DATA_W-1:0] sh_next;
    logic [CW-1:0]     cnt;
    logic [DATA_W-1:0] hold;
    logic              hold_vld;
    logic              load;
    logic              take;
    logic              ser_bit;

`ifdef SER_LSB_FIRST_EN
    assign sh_next = sh >> 1;
    assign ser_bit = sh[0];
`else
    assign sh_next = sh << 1;
    assign ser_bit = sh[DATA_W-1];
`endif

    assign load = in_valid && in_ready;
    // load needs an empty holder and take a full one, so they can never coincide
    assign take = hold_vld && ((state == S_IDLE) || (state == S_SHIFT && cnt == LAST));

    ser_hold_reg #(.DATA_W(DATA_W)) u_hold (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .load     (load),
        .take     (take),
        .hold     (hold),
        .hold_vld (hold_vld),
        .in_ready (in_ready)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            sh        <= '0;
            cnt       <= '0;
            ser_valid <= 1'b0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hold_vld) begin
                        sh        <= hold;
                        cnt       <= '0;
                        ser_valid <= 1'b1;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (cnt != LAST) begin
                        sh  <= sh_next;
                        cnt <= cnt + 1'b1;
                    end else begin
                        word_done <= 1'b1;
                        cnt       <= '0;
                        // a waiting word reloads here so the stream stays gap-free
                        if (hold_vld) begin
                            sh <= hold;
                        end else begin
                            sh        <= '0;
                            ser_valid <= 1'b0;
                            state     <= S_IDLE;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign ser_out = ser_valid & ser_bit;
    assign busy    = (state == S_SHIFT) || hold_vld;

endmodule
